// File: rtl/computation_sequencer.sv
// computation_sequencer: FIFO-buffered RSA job sequencer driving a shared modexp engine.
// Define COMPUTATION_SEQ_ECHO_EN to accept mode 2 (echo) jobs that bypass the engine.
module computation_sequencer #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] rx_data,
    input  logic [1:0]       rx_mode,
    input  logic             rx_irq,
    output logic             rx_full,
    input  logic [WIDTH-1:0] e_key,
    input  logic [WIDTH-1:0] d_key,
    input  logic [WIDTH-1:0] n,
    output logic             eng_start,
    output logic [WIDTH-1:0] eng_message,
    output logic [WIDTH-1:0] eng_exp,
    output logic [WIDTH-1:0] eng_mod,
    input  logic             eng_done,
    input  logic [WIDTH-1:0] eng_result,
    output logic [WIDTH-1:0] tx_data,
    output logic             tx_wr,
    input  logic             tx_busy,
    output logic             err_drop,
    output logic [CNT_W-1:0] jobs_done
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, EMIT} state_t;
    state_t state, state_nx;

    logic [WIDTH+1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic [WIDTH+1:0] head;
    logic             mode_ok, is_echo, push, pop, empty, emit_go;

`ifdef COMPUTATION_SEQ_ECHO_EN
    assign mode_ok = rx_mode != 2'd3;
    assign is_echo = head[WIDTH+1:WIDTH] == 2'd2;
`else
    assign mode_ok = !rx_mode[1];
    assign is_echo = 1'b0;
`endif

    // Pointers carry an extra wrap bit so full and empty are distinguishable
    assign empty     = wr_ptr == rd_ptr;
    assign rx_full   = (wr_ptr - rd_ptr) == (AW+1)'(DEPTH);
    assign push      = rx_irq && mode_ok && !rx_full;
    assign pop       = state == IDLE && !empty;
    assign head      = mem[rd_ptr[AW-1:0]];
    assign eng_start = state == ISSUE;
    assign emit_go   = state == EMIT && !tx_busy;

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {rx_mode, rx_data};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (!empty) state_nx = is_echo ? EMIT : ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    if (eng_done) state_nx = EMIT;
            default: if (!tx_busy) state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            err_drop    <= 1'b0;
            eng_message <= '0;
            eng_exp     <= '0;
            eng_mod     <= '0;
            tx_data     <= '0;
            tx_wr       <= 1'b0;
            jobs_done   <= '0;
        end else begin
            err_drop <= rx_irq && (!mode_ok || rx_full);
            tx_wr    <= emit_go;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                if (is_echo) begin
                    tx_data <= head[WIDTH-1:0];
                end else begin
                    eng_message <= head[WIDTH-1:0];
                    eng_exp     <= head[WIDTH] ? d_key : e_key;
                    eng_mod     <= n;
                end
            end
            if (state == WAIT && eng_done) tx_data <= eng_result;
            if (emit_go) jobs_done <= jobs_done + 1'b1;
        end
    end
endmodule

// File: tb/tb_computation_sequencer.sv
// tb_computation_sequencer: scoreboard bench for computation_sequencer with a behavioural engine.
// Honours COMPUTATION_SEQ_ECHO_EN to select the expected echo behaviour.
module tb_computation_sequencer;
    localparam logic [127:0] E_KEY = 128'd17;
    localparam logic [127:0] D_KEY = 128'd157;
    localparam logic [127:0] N_MOD = 128'd2773;

    typedef struct {
        logic [127:0] m;
        logic [127:0] x;
        logic [127:0] md;
    } op_t;

    logic         clock, reset;
    logic [127:0] rx_data;
    logic [1:0]   rx_mode;
    logic         rx_irq, rx_full;
    logic         eng_start, eng_done, tx_wr, tx_busy, err_drop;
    logic [127:0] eng_message, eng_exp, eng_mod, eng_result, tx_data;
    logic [2:0]   jobs_done;

    op_t          op_q[$];
    logic [127:0] res_q[$];
    op_t          mo;
    logic [127:0] mr, rm, rxp, exp_bp;
    logic [2:0]   tx_cnt;
    logic         stall, glitch;
    int           n_vec, n_bad;

    computation_sequencer #(.WIDTH(128), .DEPTH(4), .CNT_W(3)) dut (
        .clock(clock), .reset(reset), .rx_data(rx_data), .rx_mode(rx_mode), .rx_irq(rx_irq),
        .rx_full(rx_full), .e_key(E_KEY), .d_key(D_KEY), .n(N_MOD), .eng_start(eng_start),
        .eng_message(eng_message), .eng_exp(eng_exp), .eng_mod(eng_mod), .eng_done(eng_done),
        .eng_result(eng_result), .tx_data(tx_data), .tx_wr(tx_wr), .tx_busy(tx_busy),
        .err_drop(err_drop), .jobs_done(jobs_done)
    );

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    function automatic logic [127:0] model(input logic [127:0] m, input logic [127:0] x);
        if (m == 128'd920 && x == E_KEY) return 128'd948;
        if (m == 128'd948 && x == D_KEY) return 128'd920;
        return (m ^ (x << 3)) + 128'd5;
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    task automatic push(input logic [127:0] d, input logic [1:0] m, input bit ok);
        @(negedge clock);
        rx_data = d;
        rx_mode = m;
        rx_irq  = 1;
        if (ok) begin
            if (m == 2'd2) res_q.push_back(d);
            else begin
                op_q.push_back('{d, m[0] ? D_KEY : E_KEY, N_MOD});
                res_q.push_back(model(d, m[0] ? D_KEY : E_KEY));
            end
        end
        @(posedge clock);
        #1 rx_irq = 0;
        check("err_drop", {127'd0, err_drop}, {127'd0, !ok});
    endtask

    task automatic drain(input string tag);
        int i = 0;
        while (i < 400 && (op_q.size() != 0 || res_q.size() != 0)) begin
            @(negedge clock);
            i++;
        end
        check({tag, "_drain"}, op_q.size() + res_q.size(), 0);
        repeat (2) @(negedge clock);
    endtask

    task automatic wait_started(input string tag);
        int i = 0;
        while (i < 100 && op_q.size() != 0) begin
            @(negedge clock);
            i++;
        end
        check({tag, "_started"}, op_q.size(), 0);
    endtask

    // Behavioural engine: optional spurious done in the ISSUE cycle, then a real done after a delay
    initial begin
        eng_done   = 0;
        eng_result = 0;
        forever begin
            @(negedge clock);
            if (eng_start) begin
                rm  = eng_message;
                rxp = eng_exp;
                if (glitch) begin
                    eng_done   = 1;
                    eng_result = '1;
                    @(negedge clock);
                    eng_done = 0;
                end
                repeat (3) @(negedge clock);
                while (stall) @(negedge clock);
                eng_result = model(rm, rxp);
                eng_done   = 1;
                @(negedge clock);
                eng_done   = 0;
                eng_result = 0;
            end
        end
    end

    always @(negedge clock) begin
        if (reset && eng_start) begin
            if (op_q.size() == 0) check("start_unexpected", 1, 0);
            else begin
                mo = op_q.pop_front();
                check("eng_message", eng_message, mo.m);
                check("eng_exp", eng_exp, mo.x);
                check("eng_mod", eng_mod, mo.md);
            end
        end
        if (reset && tx_wr) begin
            if (res_q.size() == 0) check("tx_unexpected", 1, 0);
            else begin
                mr = res_q.pop_front();
                tx_cnt = tx_cnt + 1'b1;
                check("tx_data", tx_data, mr);
                check("jobs_done", {125'd0, jobs_done}, {125'd0, tx_cnt});
            end
        end
    end

    initial begin
        int k;
        n_vec = 0; n_bad = 0; tx_cnt = 0;
        reset = 0; rx_irq = 0; rx_data = 0; rx_mode = 0;
        tx_busy = 0; stall = 0; glitch = 0;
        repeat (3) @(negedge clock);
        check("rst_outputs", {eng_start, tx_wr, err_drop, rx_full}, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_eng_ops", eng_message | eng_exp | eng_mod, 0);
        check("rst_jobs", {125'd0, jobs_done}, 0);
        reset = 1;

        push(128'd920, 2'd0, 1);
        drain("encrypt");
        glitch = 1;
        push(128'd948, 2'd1, 1);
        drain("decrypt");
        glitch = 0;

        // Occupy the engine first so the FIFO alone absorbs the next pushes
        stall = 1;
        push(128'd100, 2'd0, 1);
        wait_started("ovf_pre");
        for (int i = 0; i < 4; i++) push(128'd200 + 128'(i), 2'(i % 2), 1);
        check("ovf_full_before", {127'd0, rx_full}, 1);
        push(128'd999, 2'd0, 0);
        check("ovf_full_after", {127'd0, rx_full}, 1);
        stall = 0;
        drain("overflow");

        tx_busy = 1;
        push(128'd555, 2'd0, 1);
        exp_bp = model(128'd555, E_KEY);
        k = 0;
        @(posedge clock);
        while (!eng_done && k < 200) begin
            @(posedge clock);
            k++;
        end
        check("bp_done_seen", {127'd0, eng_done}, 1);
        repeat (10) begin
            @(negedge clock);
            check("bp_no_wr", {127'd0, tx_wr}, 0);
            check("bp_hold", tx_data, exp_bp);
        end
        tx_busy = 0;
        @(negedge clock);
        check("bp_wr", {127'd0, tx_wr}, 1);
        drain("backpressure");

        stall = 1;
        push(128'd300, 2'd0, 1);
        wait_started("rst_pre");
        for (int i = 0; i < 3; i++) push(128'd400 + 128'(i), 2'd1, 1);
        @(negedge clock);
        reset = 0;
        #1;
        check("midrst_outputs", {eng_start, tx_wr, err_drop, rx_full}, 0);
        check("midrst_tx_data", tx_data, 0);
        check("midrst_eng_ops", eng_message | eng_exp | eng_mod, 0);
        check("midrst_jobs", {125'd0, jobs_done}, 0);
        op_q.delete();
        res_q.delete();
        tx_cnt = 0;
        repeat (2) @(negedge clock);
        reset = 1;
        stall = 0;
        repeat (30) @(negedge clock);
        check("late_done_jobs", {125'd0, jobs_done}, 0);
        check("late_done_tx_data", tx_data, 0);

        push(128'h5a5a, 2'd3, 0);
`ifdef COMPUTATION_SEQ_ECHO_EN
        push(128'h1234, 2'd2, 1);
        drain("echo");
`else
        push(128'h1234, 2'd2, 0);
        repeat (10) @(negedge clock);
        check("echo_rejected_jobs", {125'd0, jobs_done}, 0);
`endif
        push(128'd777, 2'd1, 1);
        drain("post");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end
endmodule
